// File: rtl/stopwatch_mode_ctrl.sv
// Stopwatch control: synchronizes, debounces and edge-detects three active-low buttons,
// then sequences the counter datapath through an IDLE/RUN/PAUSE/LAP Moore FSM.
module stopwatch_mode_ctrl #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_stop_button_i,
   input  logic       reset_button_i,
   input  logic       lap_button_i,
   output logic       en_o,
   output logic       reset_o,
   output logic       lap_load_o,
   output logic       freeze_o,
   output logic [1:0] state_o
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      LAP   = 2'b11
   } state_t;

   // Bit 0 = start/stop, bit 1 = reset, bit 2 = lap.
   logic [2:0]    raw;
   logic [2:0]    sync1_q;
   logic [2:0]    sync2_q;
   logic [2:0]    deb_q;
   logic [2:0]    prev_q;
   logic [CW-1:0] cnt_q [3];
   logic [2:0]    press;

   assign raw = {lap_button_i, reset_button_i, start_stop_button_i};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= '1;
         sync2_q <= '1;
         deb_q   <= '1;
         prev_q  <= '1;
         for (int b = 0; b < 3; b++) begin
            cnt_q[b] <= '0;
         end
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         prev_q  <= deb_q;
         for (int b = 0; b < 3; b++) begin
            if (sync2_q[b] == deb_q[b]) begin
               cnt_q[b] <= '0;
            end else if (cnt_q[b] == CW'(DEBOUNCE_CYCLES - 1)) begin
               // This edge is the DEBOUNCE_CYCLES-th consecutive mismatch.
               deb_q[b] <= sync2_q[b];
               cnt_q[b] <= '0;
            end else begin
               cnt_q[b] <= cnt_q[b] + CW'(1);
            end
         end
      end
   end

   // One-cycle event on each debounced fall (released -> pressed).
   assign press = prev_q & ~deb_q;

   state_t state_q, state_d;
   logic   reset_q, reset_d;
   logic   lap_q, lap_d;
   logic   ev_ss, ev_rs, ev_lp;

   assign ev_ss = press[0];
   assign ev_rs = press[1] & ~press[0];
   assign ev_lp = press[2] & ~press[1] & ~press[0];

   always_comb begin
      state_d = state_q;
      reset_d = 1'b0;
      lap_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (ev_ss) begin
               state_d = RUN;
            end else if (ev_rs) begin
               reset_d = 1'b1;
            end
         end
         RUN: begin
            if (ev_ss) begin
               state_d = PAUSE;
            end else if (ev_lp) begin
               state_d = LAP;
               lap_d   = 1'b1;
            end
         end
         LAP: begin
            if (ev_ss) begin
               state_d = PAUSE;
            end else if (ev_rs) begin
               state_d = RUN;
            end else if (ev_lp) begin
               lap_d = 1'b1;
            end
         end
         PAUSE: begin
            if (ev_ss) begin
               state_d = RUN;
            end else if (ev_rs) begin
               state_d = IDLE;
               reset_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         reset_q <= 1'b1;
         lap_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         reset_q <= reset_d;
         lap_q   <= lap_d;
      end
   end

   assign state_o    = state_q;
   assign en_o       = (state_q == RUN) || (state_q == LAP);
   assign freeze_o   = (state_q == LAP);
   assign reset_o    = reset_q;
   assign lap_load_o = lap_q;

endmodule

// File: tb/tb_stopwatch_mode_ctrl.sv
// Scoreboard bench for stopwatch_mode_ctrl with DEBOUNCE_CYCLES=4: stimulus pushes
// expected output changes (with their cycle), a negedge monitor pops and compares.
module tb_stopwatch_mode_ctrl;

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_RUN   = 2'b01;
   localparam logic [1:0] S_PAUSE = 2'b10;
   localparam logic [1:0] S_LAP   = 2'b11;
   localparam logic [2:0] B_SS = 3'b001;
   localparam logic [2:0] B_RS = 3'b010;
   localparam logic [2:0] B_LP = 3'b100;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ss_b = 1'b1;
   logic       rs_b = 1'b1;
   logic       lp_b = 1'b1;
   logic       en_o, reset_o, lap_load_o, freeze_o;
   logic [1:0] state_o;

   stopwatch_mode_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
      .clk_i               (clk),
      .rst_i               (rst),
      .start_stop_button_i (ss_b),
      .reset_button_i      (rs_b),
      .lap_button_i        (lp_b),
      .en_o                (en_o),
      .reset_o             (reset_o),
      .lap_load_o          (lap_load_o),
      .freeze_o            (freeze_o),
      .state_o             (state_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [5:0] v;   // {state, en, freeze, reset, lap_load}
   } obs_t;

   obs_t q[$];
   int   tests = 0;
   int   fails = 0;
   logic mon_en = 1'b0;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] low);
      ss_b = ~low[0];
      rs_b = ~low[1];
      lp_b = ~low[2];
   endtask

   task automatic press(input logic [2:0] m, input int hold);
      drive(m);
      tick(hold);
      drive(3'b000);
      tick(12);
   endtask

   task automatic push(input int c, input logic [1:0] st, input logic r, input logic l);
      obs_t e;
      logic en_e, fr_e;
      en_e  = (st == S_RUN) || (st == S_LAP);
      fr_e  = (st == S_LAP);
      e.cyc = c;
      e.v   = {st, en_e, fr_e, r, l};
      q.push_back(e);
   endtask

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every change of the observable outputs must match the next expected entry.
   initial begin
      logic [5:0] prev, cur;
      obs_t e;
      prev = '0;
      forever begin
         @(negedge clk);
         cur = {state_o, en_o, freeze_o, reset_o, lap_load_o};
         if (mon_en && cur != prev) begin
            tests++;
            if (q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_output: cycle %0d got %b expected no change", cyc, cur);
            end else begin
               e = q.pop_front();
               if (e.cyc != cyc || e.v != cur) begin
                  fails++;
                  $display("FAIL output_change: got %b at cycle %0d expected %b at cycle %0d",
                           cur, cyc, e.v, e.cyc);
               end
            end
         end
         prev = cur;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int base;
      // 1. reset state and release
      tick(3);
      check("rst_reset_o", int'(reset_o), 1);
      check("rst_en_o", int'(en_o), 0);
      check("rst_state_o", int'(state_o), 0);
      check("rst_freeze_o", int'(freeze_o), 0);
      check("rst_lap_load_o", int'(lap_load_o), 0);
      rst = 1'b0;
      tick(1);
      check("rel_reset_o", int'(reset_o), 0);
      tick(1);
      mon_en = 1'b1;

      // 2. clean SS press -> RUN after 7th sampling edge, second SS -> PAUSE
      base = cyc; push(base + 7, S_RUN, 1'b0, 1'b0);   press(B_SS, 10);
      base = cyc; push(base + 7, S_PAUSE, 1'b0, 1'b0); press(B_SS, 10);

      // 3. 3-cycle glitch ignored; bounce 0,1,0,0,0,... gives one event
      press(B_SS, 3);
      base = cyc; push(base + 9, S_RUN, 1'b0, 1'b0);
      drive(B_SS); tick(1);
      drive(3'b000); tick(1);
      drive(B_SS); tick(8);
      drive(3'b000); tick(12);

      // 4. laps and resume
      base = cyc; push(base + 7, S_LAP, 1'b0, 1'b1); push(base + 8, S_LAP, 1'b0, 1'b0);
      press(B_LP, 10);
      base = cyc; push(base + 7, S_LAP, 1'b0, 1'b1); push(base + 8, S_LAP, 1'b0, 1'b0);
      press(B_LP, 10);
      base = cyc; push(base + 7, S_RUN, 1'b0, 1'b0); press(B_RS, 10);

      // 5. RS ignored in RUN; pause; clear; LP ignored in PAUSE
      press(B_RS, 10);
      base = cyc; push(base + 7, S_PAUSE, 1'b0, 1'b0); press(B_SS, 10);
      base = cyc; push(base + 7, S_IDLE, 1'b1, 1'b0); push(base + 8, S_IDLE, 1'b0, 1'b0);
      press(B_RS, 10);
      base = cyc; push(base + 7, S_RUN, 1'b0, 1'b0);   press(B_SS, 10);
      base = cyc; push(base + 7, S_PAUSE, 1'b0, 1'b0); press(B_SS, 10);
      press(B_LP, 10);

      // 6. simultaneous SS+RS in PAUSE -> RUN only; rst in LAP; button held through reset
      base = cyc; push(base + 7, S_RUN, 1'b0, 1'b0); press(B_SS | B_RS, 10);
      base = cyc; push(base + 7, S_LAP, 1'b0, 1'b1); push(base + 8, S_LAP, 1'b0, 1'b0);
      press(B_LP, 10);
      check("lap_state_before_rst", int'(state_o), int'(S_LAP));
      mon_en = 1'b0;
      rst = 1'b1;
      #1;
      check("midrst_state_o", int'(state_o), 0);
      check("midrst_en_o", int'(en_o), 0);
      check("midrst_freeze_o", int'(freeze_o), 0);
      check("midrst_reset_o", int'(reset_o), 1);
      tick(2);
      drive(B_SS);
      tick(3);
      rst = 1'b0;
      base = cyc;
      push(base + 7, S_RUN, 1'b0, 1'b0);
      tick(1);
      check("held_rel_reset_o", int'(reset_o), 0);
      check("held_rel_state_o", int'(state_o), 0);
      tick(1);
      mon_en = 1'b1;
      tick(12);
      drive(3'b000);
      tick(12);

      check("queue_empty", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
